dvsd_pe_core: RTL and testbench

Registered 8-input priority encoder with enable-in, enable-out and group-select, for cascading encoders into wider request arbiters. The block samples the request vector and enable on each clock edge and presents the encoded index of the highest-numbered active request, with status flags, one cycle later. It sits between request-generating logic and any downstream index consumer, and chains with sibling instances through `en`/`eno`.

---
 rtl/dvsd_pe_core_if.sv | 16 +
 rtl/dvsd_pe_core.sv | 71 +++++++
 tb/tb_dvsd_pe_core.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dvsd_pe_core_if.sv
// Request/encode bundle for dvsd_pe_core: request vector and enable in,
// registered index plus enable-out and group-select flags back.
interface dvsd_pe_core_if #(
  parameter int WIDTH = 8
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in;
  logic             en;
  logic [OUT_W-1:0] out;
  logic             eno;
  logic             gs;

  modport master (output in, en, input out, eno, gs);
  modport slave  (input in, en, output out, eno, gs);
endinterface

// File: rtl/dvsd_pe_core.sv
// Registered priority encoder with enable-in/enable-out/group-select for cascading.
// Optional macro DVSD_PE_INREG_EN adds an input register stage (latency 2).
module dvsd_pe_core #(
  parameter int WIDTH = 8
) (
  input logic           clk,
  input logic           rst_n,
  dvsd_pe_core_if.slave pe
);
  localparam int OUT_W = $clog2(WIDTH);

  logic [WIDTH-1:0] in_p0;
  logic             en_p0;
  logic             any_p0;
  logic [OUT_W-1:0] out_nxt;
  logic             gs_nxt;
  logic             eno_nxt;
  logic [OUT_W-1:0] out_p1;
  logic             gs_p1;
  logic             eno_p1;

  // Highest set bit wins: later (higher) indices overwrite earlier ones.
  function automatic logic [OUT_W-1:0] prio_idx(input logic [WIDTH-1:0] req);
    logic [OUT_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) idx = OUT_W'(i);
    end
    return idx;
  endfunction

`ifdef DVSD_PE_INREG_EN
  // Stage p0: registered request/enable sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_p0 <= '0;
      en_p0 <= 1'b0;
    end else begin
      in_p0 <= pe.in;
      en_p0 <= pe.en;
    end
  end
`else
  assign in_p0 = pe.in;
  assign en_p0 = pe.en;
`endif

  always_comb begin
    any_p0  = |in_p0;
    gs_nxt  = en_p0 & any_p0;
    eno_nxt = en_p0 & ~any_p0;
    out_nxt = gs_nxt ? prio_idx(in_p0) : '0;
  end

  // Stage p1: output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_p1 <= '0;
      gs_p1  <= 1'b0;
      eno_p1 <= 1'b0;
    end else begin
      out_p1 <= out_nxt;
      gs_p1  <= gs_nxt;
      eno_p1 <= eno_nxt;
    end
  end

  assign pe.out = out_p1;
  assign pe.gs  = gs_p1;
  assign pe.eno = eno_p1;
endmodule

// File: tb/tb_dvsd_pe_core.sv
// Directed-vector bench for dvsd_pe_core: single instance plus a 16-bit cascade.
module tb_dvsd_pe_core;
`ifdef DVSD_PE_INREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic clk;
  logic rst_n;
  int   n_vec;
  int   n_err;

  dvsd_pe_core_if #(.WIDTH(8)) a  ();
  dvsd_pe_core_if #(.WIDTH(8)) ca ();
  dvsd_pe_core_if #(.WIDTH(8)) cb ();

  dvsd_pe_core #(.WIDTH(8)) dut   (.clk(clk), .rst_n(rst_n), .pe(a));
  dvsd_pe_core #(.WIDTH(8)) dut_a (.clk(clk), .rst_n(rst_n), .pe(ca));
  dvsd_pe_core #(.WIDTH(8)) dut_b (.clk(clk), .rst_n(rst_n), .pe(cb));

  assign cb.en = ca.eno;

  logic [3:0] comb_idx;
  assign comb_idx = {ca.gs, ca.gs ? ca.out : cb.out};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       v;
    logic [2:0] o;
    logic       g;
    logic       e;
  } exp_t;

  exp_t pipe [LAT];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic clr_pipe();
    for (int i = 0; i < LAT; i++) pipe[i] = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".out"}, 32'(a.out), 32'd0);
    chk({tag, ".gs"},  32'(a.gs),  32'd0);
    chk({tag, ".eno"}, 32'(a.eno), 32'd0);
  endtask

  // Drive one vector per cycle; compare the vector applied LAT cycles back.
  task automatic apply(input string tag, input logic [7:0] vin, input logic ven,
                       input logic [2:0] eo, input logic eg, input logic ee);
    exp_t chkv;
    @(negedge clk);
    a.in = vin;
    a.en = ven;
    @(posedge clk);
    #1;
    for (int i = LAT - 1; i > 0; i--) pipe[i] = pipe[i-1];
    pipe[0] = {1'b1, eo, eg, ee};
    chkv = pipe[LAT-1];
    if (chkv.v) begin
      chk({tag, ".out"}, 32'(a.out), 32'(chkv.o));
      chk({tag, ".gs"},  32'(a.gs),  32'(chkv.g));
      chk({tag, ".eno"}, 32'(a.eno), 32'(chkv.e));
    end
  endtask

  task automatic flush();
    for (int i = 0; i < LAT; i++) apply("flush", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
  endtask

  task automatic casc(input string tag, input logic [15:0] req,
                      input logic [3:0] eidx, input logic a_eno, input logic b_gs);
    @(negedge clk);
    ca.in = req[15:8];
    ca.en = 1'b1;
    cb.in = req[7:0];
    for (int i = 0; i < 2 * LAT; i++) @(posedge clk);
    #1;
    chk({tag, ".idx"},   32'(comb_idx), 32'(eidx));
    chk({tag, ".a_eno"}, 32'(ca.eno),   32'(a_eno));
    chk({tag, ".b_gs"},  32'(cb.gs),    32'(b_gs));
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    clr_pipe();
    rst_n = 1'b0;
    a.in  = 8'hFF;
    a.en  = 1'b1;
    ca.in = 8'h00;
    ca.en = 1'b0;
    cb.in = 8'h00;
    #3;
    chk_zero("rst_async");

    @(negedge clk);
    rst_n = 1'b1;
    apply("rst_rel", 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0);
    for (int i = 1; i < LAT; i++) apply("rst_rel", 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0);

    apply("dis_00", 8'h00, 1'b0, 3'd0, 1'b0, 1'b0);
    apply("dis_a5", 8'hA5, 1'b0, 3'd0, 1'b0, 1'b0);

    for (int k = 0; k < 8; k++) begin
      logic [7:0] v;
      v = 8'h01 << k;
      apply("walk", v, 1'b1, 3'(k), 1'b1, 1'b0);
    end

    apply("idle",  8'h00, 1'b1, 3'd0, 1'b0, 1'b1);
    apply("pri53", 8'h53, 1'b1, 3'd6, 1'b1, 1'b0);
    apply("pri03", 8'h03, 1'b1, 3'd1, 1'b1, 1'b0);
    apply("pri81", 8'h81, 1'b1, 3'd7, 1'b1, 1'b0);
    apply("pri85", 8'h85, 1'b1, 3'd7, 1'b1, 1'b0);
    apply("bit0",  8'h01, 1'b1, 3'd0, 1'b1, 1'b0);
    flush();

    // Outputs at 7 mid-stream, then async reset must clear them at once.
    for (int i = 0; i < LAT; i++) apply("pre_rst", 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0);
    chk("pre_rst.gs", 32'(a.gs), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_zero("rst_mid");
    @(posedge clk);
    #1;
    chk_zero("rst_hold");
    clr_pipe();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < LAT; i++) apply("post_rst", 8'hFF, 1'b1, 3'd7, 1'b1, 1'b0);
    flush();

    casc("casc_b3",  16'h0008, 4'd3,  1'b1, 1'b1);
    casc("casc_b12", 16'h1008, 4'd12, 1'b0, 1'b0);
    casc("casc_b15", 16'h8001, 4'd15, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end
endmodule
